sht40_frame_checker: RTL

Downstream consumer of the I2C master's receive path for the SHT40 sensor. Takes each byte the master reads and handles the repeating [MSB, LSB, CRC] word triplets. It checks each triplet with the Sensirion CRC-8 and assembles the raw temperature and humidity words. It drives back to the master the expected read count and the CRC_Error abort line.

---
 rtl/sht40_frame_checker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sht40_frame_checker.sv
// rtl/sht40_frame_checker.sv - SHT40 read-frame CRC checker and word assembler
// Optional conversion outputs: define SHT40_CONVERT_EN.
module sht40_frame_checker #(
  parameter int         NUM_WORDS = 2,
  parameter logic [7:0] CRC_POLY  = 8'h31,
  parameter logic [7:0] CRC_INIT  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Frame_Start,
  input  logic        Byte_Valid,
  input  logic [7:0]  Byte_Data,
  output logic        Byte_Ready,
  output logic [3:0]  Expected_Reads,
  output logic        CRC_Error,
  output logic        Word_Valid,
  output logic [15:0] Temp_Raw,
  output logic [15:0] Rh_Raw,
  output logic        Frame_Done,
  output logic        Frame_Ok
`ifdef SHT40_CONVERT_EN
  ,
  output logic signed [15:0] Temp_Centi,
  output logic        [15:0] Rh_Centi,
  output logic               Conv_Valid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_CRC_SHIFT, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic LAST_WORD = 1'(NUM_WORDS - 1);

  state_t     state;
  logic [1:0] tri_idx;
  logic       word_idx;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] crc;
  logic [7:0] msb_q;
  logic [7:0] lsb_q;

  assign Expected_Reads = 4'(NUM_WORDS * 3);
  assign Byte_Ready     = (state == S_COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tri_idx    <= 2'd0;
      word_idx   <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      crc        <= CRC_INIT;
      msb_q      <= 8'h00;
      lsb_q      <= 8'h00;
      CRC_Error  <= 1'b0;
      Word_Valid <= 1'b0;
      Temp_Raw   <= 16'h0000;
      Rh_Raw     <= 16'h0000;
      Frame_Done <= 1'b0;
      Frame_Ok   <= 1'b0;
    end else begin
      Word_Valid <= 1'b0;
      Frame_Done <= 1'b0;
      if (Frame_Start) begin
        // Restart wins over any byte offered in the same cycle.
        state     <= S_COLLECT;
        tri_idx   <= 2'd0;
        word_idx  <= 1'b0;
        bit_cnt   <= 3'd0;
        crc       <= CRC_INIT;
        CRC_Error <= 1'b0;
        Frame_Ok  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_COLLECT: begin
            if (Byte_Valid) begin
              if (tri_idx == 2'd2) begin
                // Flag the mismatch on acceptance so CRC_Error shows during CHECK.
                tri_idx   <= 2'd0;
                CRC_Error <= (Byte_Data != crc);
                state     <= S_CHECK;
              end else begin
                if (tri_idx == 2'd0) msb_q <= Byte_Data;
                else                 lsb_q <= Byte_Data;
                shreg   <= Byte_Data;
                bit_cnt <= 3'd0;
                tri_idx <= tri_idx + 2'd1;
                state   <= S_CRC_SHIFT;
              end
            end
          end
          S_CRC_SHIFT: begin
            crc     <= {crc[6:0], 1'b0} ^ ((crc[7] ^ shreg[7]) ? CRC_POLY : 8'h00);
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_COLLECT;
          end
          S_CHECK: begin
            if (CRC_Error) begin
              state <= S_ERROR;
            end else begin
              if (word_idx == 1'b0) Temp_Raw <= {msb_q, lsb_q};
              else                  Rh_Raw   <= {msb_q, lsb_q};
              Word_Valid <= 1'b1;
              crc        <= CRC_INIT;
              if (word_idx == LAST_WORD) begin
                state <= S_DONE;
              end else begin
                word_idx <= word_idx + 1'b1;
                state    <= S_COLLECT;
              end
            end
          end
          S_DONE: begin
            Frame_Done <= 1'b1;
            Frame_Ok   <= 1'b1;
            state      <= S_IDLE;
          end
          S_ERROR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SHT40_CONVERT_EN
  logic        [31:0] t_prod;
  logic        [31:0] r_prod;
  logic        [15:0] t_scaled;
  logic        [15:0] r_scaled;
  logic signed [16:0] t_off;
  logic signed [16:0] r_off;

  assign t_prod   = 32'd17500 * {16'd0, Temp_Raw};
  assign r_prod   = 32'd12500 * {16'd0, Rh_Raw};
  assign t_scaled = 16'(t_prod >> 16);
  assign r_scaled = 16'(r_prod >> 16);
  assign t_off    = $signed({1'b0, t_scaled}) - 17'sd4500;
  assign r_off    = $signed({1'b0, r_scaled}) - 17'sd600;

  // Words are already committed when Frame_Done fires, so sample on that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Temp_Centi <= 16'sd0;
      Rh_Centi   <= 16'd0;
      Conv_Valid <= 1'b0;
    end else begin
      Conv_Valid <= Frame_Done;
      if (Frame_Done) begin
        Temp_Centi <= t_off[15:0];
        if (r_off < 17'sd0)          Rh_Centi <= 16'd0;
        else if (r_off > 17'sd10000) Rh_Centi <= 16'd10000;
        else                         Rh_Centi <= r_off[15:0];
      end
    end
  end
`endif

endmodule
